// File: rtl/mandelbrot_cfg_pkg.sv
// mandelbrot_cfg_pkg: config word layout and serial-link FSM states shared by the mandelbrot config transmitter and receiver
package mandelbrot_cfg_pkg;
  localparam int CFG_WIDTH = 52;
  localparam int CR_OFFSET_LSB = 0;
  localparam int CR_OFFSET_W = 16;
  localparam int CI_OFFSET_LSB = 16;
  localparam int CI_OFFSET_W = 16;
  localparam int SCALING_LSB = 32;
  localparam int SCALING_W = 7;
  localparam int CTR_SELECT_LSB = 39;
  localparam int CTR_SELECT_W = 3;
  localparam int MAX_CTR_LSB = 42;
  localparam int MAX_CTR_W = 10;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL} cfg_state_e;
  function automatic logic [CFG_WIDTH-1:0] cfg_pack(
    input logic [MAX_CTR_W-1:0] max_ctr,
    input logic [CTR_SELECT_W-1:0] ctr_select,
    input logic [SCALING_W-1:0] scaling,
    input logic [CI_OFFSET_W-1:0] ci_offset,
    input logic [CR_OFFSET_W-1:0] cr_offset
  );
    return {max_ctr, ctr_select, scaling, ci_offset, cr_offset};
  endfunction
endpackage

// File: rtl/cfg_phase_timer.sv
// cfg_phase_timer: counts HALF_PERIOD cycles per FSM state and flags the last and second-to-last cycle
module cfg_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic phase_end,
  output logic near_end
);
  localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  logic [TW-1:0] t_q, t_d;
  always_comb begin
    phase_end = active && (t_q == TW'(HALF_PERIOD - 1));
    near_end = active && (t_q == TW'(HALF_PERIOD - 2));
    t_d = (!active || restart) ? '0 : t_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    t_q <= !rst_n ? '0 : t_d;
  end
endmodule

// File: rtl/cfg_serial_tx.sv
// cfg_serial_tx: 3-wire (sen/sclk/sdata) serial master shifting a config word out LSB-first
module cfg_serial_tx
  import mandelbrot_cfg_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             sen,
  output logic             sclk,
  output logic             sdata
);
  localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  cfg_state_e state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [NW-1:0] n_q, n_d;
  logic last_q, last_d;
  logic busy_q, busy_d, done_q, done_d, sen_q, sen_d, sclk_q, sclk_d, sdata_q, sdata_d;
  logic phase_end, near_end;
  cfg_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .active(state_q != IDLE),
    .restart(state_d != state_q),
    .phase_end(phase_end),
    .near_end(near_end)
  );
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    n_d = n_q;
    last_d = last_q;
    sdata_d = sdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        sr_d = data;
        n_d = '0;
        last_d = 1'b0;
        sdata_d = data[0];
      end
      SETUP: state_d = phase_end ? HIGH : SETUP;
      // the next bit is presented on the sclk fall so it is stable for a whole low phase before the rise
      HIGH: if (phase_end) begin
        state_d = LOW;
        last_d = n_q == NW'(WIDTH - 1);
        if (!last_d) begin
          sr_d = sr_q >> 1;
          n_d = n_q + 1'b1;
          sdata_d = sr_q[1];
        end
      end
      LOW: if (phase_end) begin
        state_d = last_q ? TAIL : HIGH;
        sdata_d = last_q ? 1'b0 : sdata_q;
      end
      TAIL: state_d = phase_end ? IDLE : TAIL;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    sen_d = state_d inside {SETUP, HIGH, LOW};
    sclk_d = state_d == HIGH;
    done_d = (state_q == TAIL) && near_end;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      n_q <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sen_q <= 1'b0;
      sclk_q <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      n_q <= n_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sen_q <= sen_d;
      sclk_q <= sclk_d;
      sdata_q <= sdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sen = sen_q;
  assign sclk = sclk_q;
  assign sdata = sdata_q;
endmodule

// File: tb/tb_cfg_serial_tx.sv
// tb_cfg_serial_tx: directed vectors plus protocol monitor and receiver model for two cfg_serial_tx instances
module tb_cfg_serial_tx;
  import mandelbrot_cfg_pkg::*;
  localparam int W = CFG_WIDTH;
  localparam int H0 = 4;
  localparam int H1 = 2;
  typedef struct {
    logic [W-1:0] d;
    logic [9:0] max_ctr;
    logic [6:0] scaling;
    logic [2:0] ctr_sel;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] busy, done, sen, sclk, sdata;
  logic [W-1:0] data [2];
  int checks = 0;
  int errors = 0;
  int proto_errs = 0;
  int rises_tot [2] = '{0, 0};
  int done_tot [2] = '{0, 0};
  int busy_tot [2] = '{0, 0};
  int renders_tot [2] = '{0, 0};
  int run [2] = '{0, 0};
  logic [W-1:0] rx [2];
  logic [W-1:0] rx_word [2];
  logic [1:0] p_sclk = 0, p_sdata = 0, p_sen = 0, p_done = 0, fell = 0;
  vec_t tbl [5];
  always #5 clk = ~clk;
  cfg_serial_tx #(.WIDTH(W), .HALF_PERIOD(H0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .data(data[0]),
    .busy(busy[0]), .done(done[0]), .sen(sen[0]), .sclk(sclk[0]), .sdata(sdata[0])
  );
  cfg_serial_tx #(.WIDTH(W), .HALF_PERIOD(H1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .data(data[1]),
    .busy(busy[1]), .done(done[1]), .sen(sen[1]), .sclk(sclk[1]), .sdata(sdata[1])
  );
  function automatic int hp(input int i);
    return (i == 1) ? H1 : H0;
  endfunction
  task automatic proto(input string name, input int i);
    proto_errs++;
    $display("FAIL proto_%s dut%0d at %0t: got violation, required none", name, i, $time);
  endtask
  // protocol checker and receiver model, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] === 1'b1) busy_tot[i]++;
      if (done[i] === 1'b1) done_tot[i]++;
      if (sclk[i] === 1'b1 && sen[i] !== 1'b1) proto("sclk_without_sen", i);
      if (done[i] === 1'b1 && busy[i] !== 1'b1) proto("done_without_busy", i);
      if (p_done[i] && (done[i] !== 1'b0 || busy[i] !== 1'b0)) proto("done_not_last", i);
      if (sclk[i] === 1'b1 && p_sclk[i] && sdata[i] !== p_sdata[i]) proto("sdata_unstable", i);
      if (sclk[i] === 1'b1 && !p_sclk[i]) begin
        if (sdata[i] !== p_sdata[i]) proto("sdata_at_rise", i);
        if (fell[i] && run[i] != hp(i)) proto("low_len", i);
        rises_tot[i]++;
        rx[i] = {sdata[i], rx[i][W-1:1]};
      end
      if (sclk[i] === 1'b0 && p_sclk[i] && rst_n && run[i] != hp(i)) proto("high_len", i);
      if (sen[i] !== 1'b1) fell[i] = 1'b0;
      else if (sclk[i] === 1'b0 && p_sclk[i]) fell[i] = 1'b1;
      run[i] = (sclk[i] !== p_sclk[i]) ? 1 : run[i] + 1;
      if (p_sen[i] && sen[i] === 1'b0) begin
        rx_word[i] = rx[i];
        renders_tot[i]++;
      end
      p_sclk[i] = sclk[i] === 1'b1;
      p_sdata[i] = sdata[i] === 1'b1;
      p_sen[i] = sen[i] === 1'b1;
      p_done[i] = done[i] === 1'b1;
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_idle(input int i, input string tag);
    int cyc = 0;
    while (busy[i] !== 1'b0 && cyc < 1000) begin
      step();
      cyc++;
    end
    check($sformatf("%s_timeout", tag), 64'(busy[i]), 64'd0);
  endtask
  task automatic txn(input int i, input logic [W-1:0] d, input string tag);
    int r0, d0, b0, n0;
    r0 = rises_tot[i];
    d0 = done_tot[i];
    b0 = busy_tot[i];
    n0 = renders_tot[i];
    data[i] = d;
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    check($sformatf("%s_busy_rise", tag), 64'(busy[i]), 64'd1);
    wait_idle(i, tag);
    check($sformatf("%s_busy_len", tag), 64'(busy_tot[i] - b0), (i == 1) ? 64'd212 : 64'd424);
    check($sformatf("%s_rises", tag), 64'(rises_tot[i] - r0), 64'd52);
    check($sformatf("%s_done_cnt", tag), 64'(done_tot[i] - d0), 64'd1);
    check($sformatf("%s_renders", tag), 64'(renders_tot[i] - n0), 64'd1);
    check($sformatf("%s_word", tag), 64'(rx_word[i]), 64'(d));
  endtask
  initial begin
    int r0, d0, cyc;
    logic [W-1:0] a, b;
    tbl[0] = '{52'h3FF_0A_5A5A_C3C3, 10'd255, 7'h0A, 3'd6};
    tbl[1] = '{cfg_pack(10'd200, 3'd2, 7'd3, 16'h1234, 16'hABCD), 10'd200, 7'd3, 3'd2};
    tbl[2] = '{52'hF_FFFF_FFFF_FFFF, 10'd1023, 7'd127, 3'd7};
    tbl[3] = '{52'h0_0000_0000_0001, 10'd0, 7'd0, 3'd0};
    tbl[4] = '{52'h8_0000_0000_0000, 10'd512, 7'd0, 3'd0};
    data[0] = '0;
    data[1] = '0;
    rx[0] = '0;
    rx[1] = '0;
    start = 2'b11;
    repeat (3) step();
    check("reset_outputs", 64'({busy, done, sen, sclk, sdata}), 64'd0);
    start = 2'b00;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 64'(busy), 64'd0);
    for (int v = 0; v < 5; v++) begin
      txn(0, tbl[v].d, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_max_ctr", v), 64'(rx_word[0][MAX_CTR_LSB +: MAX_CTR_W]), 64'(tbl[v].max_ctr));
      check($sformatf("vec%0d_scaling", v), 64'(rx_word[0][SCALING_LSB +: SCALING_W]), 64'(tbl[v].scaling));
      check($sformatf("vec%0d_ctr_sel", v), 64'(rx_word[0][CTR_SELECT_LSB +: CTR_SELECT_W]), 64'(tbl[v].ctr_sel));
    end
    a = tbl[0].d;
    b = tbl[1].d;
    r0 = rises_tot[0];
    d0 = done_tot[0];
    data[0] = a;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (9) step();
    data[0] = b;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (89) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    data[0] = '0;
    cyc = 0;
    while (done[0] !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
    check("busy_start_done_seen", 64'(done[0]), 64'd1);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("start_on_done_ignored", 64'(busy[0]), 64'd0);
    step();
    check("still_idle", 64'(busy[0]), 64'd0);
    check("busy_start_word", 64'(rx_word[0]), 64'(a));
    check("busy_start_rises", 64'(rises_tot[0] - r0), 64'd52);
    check("busy_start_done_cnt", 64'(done_tot[0] - d0), 64'd1);
    txn(0, b, "second");
    r0 = rises_tot[0];
    data[0] = tbl[2].d;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    cyc = 0;
    while (rises_tot[0] - r0 < 21 && cyc < 1000) begin
      step();
      cyc++;
    end
    check("bit20_reached", 64'(rises_tot[0] - r0), 64'd21);
    d0 = done_tot[0];
    rst_n = 1'b0;
    step();
    check("midreset_outputs", 64'({busy[0], done[0], sen[0], sclk[0], sdata[0]}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("midreset_no_done", 64'(done_tot[0] - d0), 64'd0);
    txn(0, tbl[1].d, "after_reset");
    txn(1, tbl[0].d, "half2_vec0");
    txn(1, tbl[2].d, "half2_vec2");
    step();
    check("protocol_violations", 64'(proto_errs), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
